muldiv_ctrl: RTL

//  Sequencer for the HI/LO register pair. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode.

---
 rtl/muldiv_ctrl_pkg.sv | 26 ++
 rtl/muldiv_ctrl_if.sv | 25 ++
 rtl/muldiv_ctrl_step.sv | 32 +++
 rtl/muldiv_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes,
// controller states and the datapath step mode.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIX   = 2'd2,
    S_WRITE = 2'd3
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Decode-side handshake and HI/LO write port of the multiply/divide sequencer.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               op_valid;
  logic [2:0]         op;
  logic [WIDTH-1:0]   rs_val;
  logic [WIDTH-1:0]   rt_val;
  logic               mf_req;
  logic               abort;
  logic               busy;
  logic               stall;
  logic [2*WIDTH-1:0] hilo_d;
  logic [1:0]         hilo_write;

  modport master (
    output op_valid, op, rs_val, rt_val, mf_req, abort,
    input  busy, stall, hilo_d, hilo_write
  );

  modport slave (
    input  op_valid, op, rs_val, rt_val, mf_req, abort,
    output busy, stall, hilo_d, hilo_write
  );
endinterface

// File: rtl/muldiv_ctrl_step.sv
// One combinational iteration of the bit-serial datapath: a shift-add multiply
// step or a restoring divide step over a 2*WIDTH+1 bit accumulator.
module muldiv_ctrl_step
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  acc,
  input  logic [WIDTH-1:0]  operand,
  input  step_mode_e        mode,
  output logic [2*WIDTH:0]  acc_next
);

  logic [WIDTH:0]   mul_sum_s;
  logic [2*WIDTH:0] shifted_s;
  logic [WIDTH+1:0] diff_s;

  // Multiply adds into the upper half then shifts right; divide shifts left
  // and keeps the trial subtraction only when it does not borrow.
  always_comb begin
    mul_sum_s = acc[0] ? (acc[2*WIDTH:WIDTH] + {1'b0, operand}) : acc[2*WIDTH:WIDTH];
    shifted_s = {acc[2*WIDTH-1:0], 1'b0};
    diff_s    = {1'b0, shifted_s[2*WIDTH:WIDTH]} - {2'b00, operand};
    case (mode)
      STEP_MUL: acc_next = {1'b0, mul_sum_s, acc[WIDTH-1:1]};
      STEP_DIV: acc_next = diff_s[WIDTH+1] ? shifted_s
                                           : {diff_s[WIDTH:0], shifted_s[WIDTH-1:1], 1'b1};
      default:  acc_next = acc;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: accepts mul/div/MTHI/MTLO from decode, iterates the serial
// datapath, fixes signs and pulses the HI/LO write port; stalls decode while busy.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_ctrl_if.slave  bus
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               sign_a_r;
  logic               sign_b_r;
  logic               is_div_r;
  logic               busy_r;
  logic [1:0]         hilo_write_r;
  logic [2*WIDTH-1:0] hilo_d_r;
  logic [2*WIDTH:0]   acc_r;
  logic [WIDTH-1:0]   opnd_r;

  logic [2*WIDTH:0]   acc_next_s;
  logic               signed_op_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [2*WIDTH-1:0] fix_d_s;

  muldiv_ctrl_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_r),
    .operand  (opnd_r),
    .mode     (is_div_r ? STEP_DIV : STEP_MUL),
    .acc_next (acc_next_s)
  );

  // Operand magnitudes for signed ops; the most negative value maps to itself.
  always_comb begin
    signed_op_s = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    mag_a_s     = (signed_op_s && bus.rs_val[WIDTH-1]) ? -bus.rs_val : bus.rs_val;
    mag_b_s     = (signed_op_s && bus.rt_val[WIDTH-1]) ? -bus.rt_val : bus.rt_val;
  end

  // Sign fix-up: sign flags are zero for unsigned ops, so results pass through.
  always_comb begin
    quo_fix_s  = (sign_a_r ^ sign_b_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_fix_s  = sign_a_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    prod_fix_s = (sign_a_r ^ sign_b_r) ? -acc_r[2*WIDTH-1:0] : acc_r[2*WIDTH-1:0];
    fix_d_s    = is_div_r ? {rem_fix_s, quo_fix_s} : prod_fix_s;
  end

  // Sequencer FSM with counter, sign flags, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      sign_a_r     <= 1'b0;
      sign_b_r     <= 1'b0;
      is_div_r     <= 1'b0;
      busy_r       <= 1'b0;
      hilo_write_r <= 2'b00;
      hilo_d_r     <= '0;
      acc_r        <= '0;
      opnd_r       <= '0;
    end else if (bus.abort) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      busy_r       <= 1'b0;
      hilo_write_r <= 2'b00;
    end else begin
      case (state_r)
        S_IDLE: begin
          hilo_write_r <= 2'b00;
          if (bus.op_valid) begin
            case (bus.op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state_r  <= S_RUN;
                busy_r   <= 1'b1;
                cnt_r    <= '0;
                acc_r    <= {{(WIDTH + 1){1'b0}}, mag_a_s};
                opnd_r   <= mag_b_s;
                sign_a_r <= signed_op_s & bus.rs_val[WIDTH-1];
                sign_b_r <= signed_op_s & bus.rt_val[WIDTH-1];
                is_div_r <= bus.op[1];
              end
              OP_MTHI: begin
                state_r      <= S_WRITE;
                busy_r       <= 1'b1;
                hilo_d_r     <= {bus.rs_val, {WIDTH{1'b0}}};
                hilo_write_r <= 2'b10;
              end
              OP_MTLO: begin
                state_r      <= S_WRITE;
                busy_r       <= 1'b1;
                hilo_d_r     <= {{WIDTH{1'b0}}, bus.rs_val};
                hilo_write_r <= 2'b01;
              end
              default: state_r <= S_IDLE;
            endcase
          end
        end
        S_RUN: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            state_r <= S_FIX;
          end
        end
        S_FIX: begin
          hilo_d_r     <= fix_d_s;
          hilo_write_r <= 2'b11;
          state_r      <= S_WRITE;
        end
        S_WRITE: begin
          hilo_write_r <= 2'b00;
          busy_r       <= 1'b0;
          state_r      <= S_IDLE;
        end
        default: begin
          hilo_write_r <= 2'b00;
          busy_r       <= 1'b0;
          state_r      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.stall      = busy_r & (bus.op_valid | bus.mf_req);
  assign bus.hilo_d     = hilo_d_r;
  // A flush in the WRITE cycle must not commit the pending HI/LO update.
  assign bus.hilo_write = hilo_write_r & {2{~bus.abort}};

endmodule
